// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB requester and its wait timer.
package apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_TIMEOUT    = 255;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  // Wide enough to hold the value TIMEOUT itself.
  function automatic int apb_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int APB_CNT_WIDTH = apb_cnt_width(APB_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter; expired marks the wait cycle that brings the count to TIMEOUT.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT,
  parameter int CNT_W   = apb_cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = enable && (count_reg >= LAST);

endmodule

// File: rtl/apb_master.sv
// APB4 requester: one command in, one SETUP/ACCESS transfer out, one response back.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

  apb_state_e              state_reg;
  logic                    cmd_ready_reg;
  logic                    psel_reg;
  logic                    penable_reg;
  logic                    pwrite_reg;
  logic [ADDR_WIDTH-1:0]   paddr_reg;
  logic [DATA_WIDTH-1:0]   pwdata_reg;
  logic [STRB_W-1:0]       pstrb_reg;
  logic                    rsp_valid_reg;
  apb_rsp_t                rsp_reg;

  logic misaligned;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  assign misaligned   = |(cmd_addr & ALIGN_MASK);
  assign timer_clear  = (state_reg == IDLE);
  assign timer_enable = (state_reg == ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_reg <= 1'b0;
            if (misaligned) begin
              // Rejected locally: the bus never sees this command.
              rsp_reg       <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              pwrite_reg <= cmd_write;
              paddr_reg  <= cmd_addr;
              pwdata_reg <= cmd_wdata;
              pstrb_reg  <= cmd_write ? cmd_strb : '0;
              psel_reg   <= 1'b1;
              state_reg  <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion on the last allowed cycle still succeeds.
          if (pready) begin
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_reg.rdata <= (pwrite_reg || pslverr) ? '0 : prdata;
            rsp_reg.err   <= pslverr;
            rsp_reg.timeout <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (timer_expired) begin
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_reg       <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign psel        = psel_reg;
  assign penable     = penable_reg;
  assign pwrite      = pwrite_reg;
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign pstrb       = pstrb_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_reg.rdata;
  assign rsp_err     = rsp_reg.err;
  assign rsp_timeout = rsp_reg.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed scoreboard bench for apb_master with a small APB memory responder.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  pstrb;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          acc;
    int          gap;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  // APB responder: word memory, programmable wait states, stuck-low pready, pslverr.
  logic [31:0] mem [0:255];
  int cfg_waits = 0;
  bit cfg_stuck = 1'b0;
  bit cfg_err   = 1'b0;
  int slv_n     = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        if (cfg_stuck || slv_n < cfg_waits) begin
          pready  = 1'b0;
          pslverr = 1'b0;
          prdata  = 32'h0;
        end else begin
          pready  = 1'b1;
          pslverr = cfg_err;
          prdata  = pwrite ? 32'h0BAD_F00D : mem[paddr[9:2]];
          if (pwrite && !cfg_err) begin
            for (int b = 0; b < 4; b++)
              if (pstrb[b]) mem[paddr[9:2]][8*b +: 8] = pwdata[8*b +: 8];
          end
        end
        slv_n++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'hFFFF_FFFF;
        slv_n   = 0;
      end
    end
  end

  // Response-side back-pressure: hold rsp_ready low for stall_left cycles of RESP.
  int stall_left = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid && stall_left > 0) begin
        rsp_ready  = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: tracks the APB phases and pops the scoreboard on each response handshake.
  initial begin
    int setup_n, access_n, first_cyc, stall_n, prev_acc;
    bit stable_ok, prot_ok, prev_v;
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_strb;
    logic        s_wr;
    logic [31:0] st_rdata;
    logic        st_err, st_to;
    exp_t e;
    setup_n = 0; access_n = 0; first_cyc = 0; stall_n = 0; prev_acc = 0;
    stable_ok = 1'b1; prot_ok = 1'b1; prev_v = 1'b0;
    s_addr = '0; s_wdata = '0; s_strb = '0; s_wr = 1'b0;
    st_rdata = '0; st_err = 1'b0; st_to = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        setup_n = 0; access_n = 0; stall_n = 0;
        stable_ok = 1'b1; prot_ok = 1'b1; prev_v = 1'b0;
      end else begin
        if (penable && !psel) prot_ok = 1'b0;
        if (psel && (cmd_ready || rsp_valid)) prot_ok = 1'b0;
        if (psel && !penable) begin
          setup_n++;
          s_addr = paddr; s_wdata = pwdata; s_strb = pstrb; s_wr = pwrite;
        end
        if (psel && penable) begin
          access_n++;
          if (paddr !== s_addr || pwdata !== s_wdata || pstrb !== s_strb || pwrite !== s_wr)
            stable_ok = 1'b0;
        end
        if (rsp_valid && !prev_v) first_cyc = cyc;
        prev_v = rsp_valid;

        if (rsp_valid && !rsp_ready) begin
          if (stall_n > 0) begin
            check("stall_rdata", rsp_rdata, st_rdata);
            check("stall_err", 32'(rsp_err), 32'(st_err));
            check("stall_timeout", 32'(rsp_timeout), 32'(st_to));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
          end
          st_rdata = rsp_rdata; st_err = rsp_err; st_to = rsp_timeout;
          stall_n++;
        end else begin
          stall_n = 0;
        end

        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("[TB] rsp addr=0x%04h wr=%0b rdata=0x%08h err=%0b to=%0b lat=%0d access=%0d",
                     e.addr, e.wr, rsp_rdata, rsp_err, rsp_timeout,
                     first_cyc - e.acc_cyc + 1, access_n);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            check("latency", 32'(first_cyc - e.acc_cyc + 1), 32'(e.lat));
            check("access_cycles", 32'(access_n), 32'(e.acc));
            check("setup_cycles", 32'(setup_n), (e.acc > 0) ? 32'd1 : 32'd0);
            if (e.acc > 0) begin
              check("paddr", 32'(s_addr), 32'(e.addr));
              check("pstrb", 32'(s_strb), 32'(e.pstrb));
              check("pwrite", 32'(s_wr), 32'(e.wr));
              if (e.wr) check("pwdata", s_wdata, e.wdata);
            end
            check("apb_stable", 32'(stable_ok), 32'd1);
            check("apb_protocol", 32'(prot_ok), 32'd1);
            if (e.gap > 0) check("issue_gap", 32'(e.acc_cyc - prev_acc), 32'(e.gap));
            prev_acc = e.acc_cyc;
          end
          setup_n = 0; access_n = 0;
          stable_ok = 1'b1; prot_ok = 1'b1;
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with cmd_ready high again.
  task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input bit stuck, input bit err,
                      input logic [31:0] exp_rdata, input bit exp_err, input bit exp_to,
                      input int lat, input int acc, input int gap);
    exp_t e;
    int n;
    cfg_waits = waits; cfg_stuck = stuck; cfg_err = err;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.pstrb = wr ? strb : 4'h0;
    e.rdata = exp_rdata; e.err = exp_err; e.to = exp_to;
    e.lat = lat; e.acc = acc; e.gap = gap; e.acc_cyc = cyc;
    sb_q.push_back(e);
    cmd_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("complete_wait", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[128] = 32'hA5A5_A5A5;
    mem[32]  = 32'h55AA_55AA;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_psel", 32'(psel), 32'd0);
    check("reset_penable", 32'(penable), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_paddr", 32'(paddr), 32'd0);
    check("reset_pstrb", 32'(pstrb), 32'd0);
    @(negedge clk);

    //    wr addr      wdata         strb  wt stk err  exp_rdata     eer eto lat acc gap
    send(1, 16'h0040, 32'hDEADBEEF, 4'h3, 0, 0, 0, 32'h0000_0000, 0, 0, 3, 1, 0);
    send(0, 16'h0040, 32'h0,        4'hF, 0, 0, 0, 32'h0000_BEEF, 0, 0, 3, 1, 4);
    send(1, 16'h0040, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0000_0000, 0, 0, 3, 1, 4);
    send(0, 16'h0040, 32'h0,        4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 3, 1, 4);
    send(1, 16'h0100, 32'h12345678, 4'hF, 0, 0, 0, 32'h0000_0000, 0, 0, 3, 1, 4);
    send(0, 16'h0100, 32'h0,        4'h0, 5, 0, 0, 32'h1234_5678, 0, 0, 8, 6, 4);
    send(0, 16'h0200, 32'h0,        4'h0, 0, 1, 0, 32'h0000_0000, 1, 1, 10, 8, 0);
    send(0, 16'h0200, 32'h0,        4'h0, 7, 0, 0, 32'hA5A5_A5A5, 0, 0, 10, 8, 0);
    send(1, 16'h0042, 32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0, 0);
    send(0, 16'h0081, 32'h0,        4'h0, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0, 2);
    send(0, 16'h0080, 32'h0,        4'h0, 0, 0, 1, 32'h0000_0000, 1, 0, 3, 1, 2);
    send(1, 16'h0080, 32'h11112222, 4'hF, 0, 0, 1, 32'h0000_0000, 1, 0, 3, 1, 4);
    send(0, 16'h0080, 32'h0,        4'h0, 0, 0, 0, 32'h55AA_55AA, 0, 0, 3, 1, 4);
    stall_left = 3;
    send(0, 16'h0040, 32'h0,        4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 3, 1, 4);
    send(0, 16'h0100, 32'h0,        4'h0, 0, 0, 0, 32'h1234_5678, 0, 0, 3, 1, 7);

    // Reset while the slave holds the transfer in ACCESS.
    cfg_stuck = 1'b1;
    cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_access", 32'(penable), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset mid-access: psel=%0b penable=%0b rsp_valid=%0b cmd_ready=%0b",
             psel, penable, rsp_valid, cmd_ready);
    check("midrst_psel", 32'(psel), 32'd0);
    check("midrst_penable", 32'(penable), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    cfg_stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    send(0, 16'h0040, 32'h0,        4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 3, 1, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
